// File: rtl/round_judge.sv
// Reaction-game round judge: loads a target pattern, samples the player switches on
// divider ticks, and scores each round. Optional feature macro: MISS_LIMIT_EN.
module round_judge #(
  parameter int unsigned ROUNDS = 10,
  parameter int unsigned WINDOW = 4
) (
  input  logic       board_clk,
  input  logic       rst_btn,
  input  logic       start,
  input  logic       tick,
  input  logic [3:0] SW,
  input  logic [3:0] pattern,
  output logic       pat_req,
  output logic [3:0] target,
  output logic       roundres,
  output logic       round_done,
  output logic [3:0] count,
  output logic [3:0] score,
  output logic       game
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CAPT  = 3'd2;
  localparam logic [2:0] PLAY  = 3'd3;
  localparam logic [2:0] JUDGE = 3'd4;
  localparam logic [2:0] OVER  = 3'd5;

  localparam logic [3:0] ROUNDS_L = 4'(ROUNDS);
  localparam logic [3:0] WINDOW_L = 4'(WINDOW);

  logic [2:0] state;
  logic [3:0] tick_cnt;
  logic       sw_match;
  logic       window_end;
  logic       miss_stop;

  assign sw_match   = (SW == target);
  assign window_end = (tick_cnt == WINDOW_L - 4'd1);

`ifdef MISS_LIMIT_EN
  logic [1:0] miss_cnt;

  always_ff @(posedge board_clk) begin
    if (rst_btn) begin
      miss_cnt <= '0;
    end else if (((state == IDLE) || (state == OVER)) && start) begin
      miss_cnt <= '0;
    end else if ((state == PLAY) && tick) begin
      if (sw_match)
        miss_cnt <= '0;
      else if (window_end)
        miss_cnt <= miss_cnt + 2'd1;
    end
  end

  assign miss_stop = (miss_cnt == 2'd3);
`else
  assign miss_stop = 1'b0;
`endif

  // roundres/count/score update on the deciding tick so they are already valid
  // during the JUDGE cycle that carries round_done.
  always_ff @(posedge board_clk) begin
    if (rst_btn) begin
      state    <= IDLE;
      tick_cnt <= '0;
      target   <= '0;
      roundres <= 1'b0;
      count    <= '0;
      score    <= '0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state    <= LOAD;
            target   <= '0;
            roundres <= 1'b0;
            count    <= '0;
            score    <= '0;
          end
        end
        LOAD: state <= CAPT;
        CAPT: begin
          target   <= pattern;
          tick_cnt <= '0;
          state    <= PLAY;
        end
        PLAY: begin
          if (tick) begin
            if (sw_match) begin
              roundres <= 1'b1;
              count    <= count + 4'd1;
              score    <= score + 4'd1;
              state    <= JUDGE;
            end else if (window_end) begin
              roundres <= 1'b0;
              count    <= count + 4'd1;
              state    <= JUDGE;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        JUDGE: state <= ((count == ROUNDS_L) || miss_stop) ? OVER : LOAD;
        default: state <= IDLE;
      endcase
    end
  end

  assign pat_req    = (state == LOAD);
  assign round_done = (state == JUDGE);
  assign game       = (state == LOAD) || (state == CAPT) || (state == PLAY) || (state == JUDGE);

endmodule

// File: tb/tb_round_judge.sv
// Self-checking bench for round_judge: sequential game model plus directed scenarios.
// Honours MISS_LIMIT_EN the same way the design does.
module tb_round_judge;

  localparam int unsigned ROUNDS = 10;
  localparam int unsigned WINDOW = 4;

  logic       board_clk = 1'b0;
  logic       rst_btn   = 1'b1;
  logic       start     = 1'b0;
  logic       tick      = 1'b0;
  logic [3:0] SW        = '0;
  logic [3:0] pattern   = '0;
  logic       pat_req;
  logic [3:0] target;
  logic       roundres;
  logic       round_done;
  logic [3:0] count;
  logic [3:0] score;
  logic       game;

  round_judge #(.ROUNDS(ROUNDS), .WINDOW(WINDOW)) dut (
    .board_clk (board_clk),
    .rst_btn   (rst_btn),
    .start     (start),
    .tick      (tick),
    .SW        (SW),
    .pattern   (pattern),
    .pat_req   (pat_req),
    .target    (target),
    .roundres  (roundres),
    .round_done(round_done),
    .count     (count),
    .score     (score),
    .game      (game)
  );

  always #5 board_clk = ~board_clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Game model: a straight-line script of one game, restarted on reset.
  logic       m_pat_req, m_round_done, m_roundres, m_game;
  logic [3:0] m_target, m_count, m_score;
  int unsigned m_miss_run;

  task automatic m_clear();
    m_pat_req = 0; m_round_done = 0; m_roundres = 0; m_game = 0;
    m_target = '0; m_count = '0; m_score = '0; m_miss_run = 0;
  endtask

  task automatic m_edge(output bit r);
    @(posedge board_clk);
    r = rst_btn;
    if (r) m_clear();
  endtask

  initial begin : model
    bit r;
    bit hit;
    bit decided;
    bit over;
    int unsigned misses;
    m_clear();
    forever begin
      m_edge(r);
      if (r || !start) continue;
      m_count = '0; m_score = '0; m_roundres = 0; m_target = '0; m_miss_run = 0;
      m_game = 1;
      forever begin
        m_pat_req = 1;
        m_edge(r); if (r) break;
        m_pat_req = 0;
        m_edge(r); if (r) break;
        m_target = pattern;
        misses = 0; decided = 0; hit = 0;
        while (!decided) begin
          m_edge(r); if (r) break;
          if (tick) begin
            if (SW == m_target) begin
              hit = 1; decided = 1;
            end else begin
              misses++;
              if (misses == WINDOW) begin hit = 0; decided = 1; end
            end
          end
        end
        if (r) break;
        m_round_done = 1;
        m_roundres   = hit;
        m_count      = m_count + 4'd1;
        if (hit) m_score = m_score + 4'd1;
        m_miss_run = hit ? 0 : m_miss_run + 1;
        m_edge(r); if (r) break;
        m_round_done = 0;
        over = (m_count == ROUNDS);
`ifdef MISS_LIMIT_EN
        if (m_miss_run == 3) over = 1;
`endif
        if (over) begin m_game = 0; break; end
      end
    end
  end

  always @(negedge board_clk) begin
    if (chk_en) begin
      check("pat_req",    {3'b0, pat_req},    {3'b0, m_pat_req});
      check("target",     target,             m_target);
      check("roundres",   {3'b0, roundres},   {3'b0, m_roundres});
      check("round_done", {3'b0, round_done}, {3'b0, m_round_done});
      check("count",      count,              m_count);
      check("score",      score,              m_score);
      check("game",       {3'b0, game},       {3'b0, m_game});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Entered at a negedge in LOAD; returns at the negedge of the JUDGE cycle.
  task automatic play_round(input logic [3:0] pat, input logic [3:0] wrong_sw,
                            input int unsigned n_wrong, input bit hit,
                            input bit disturb, input logic [3:0] exp_count);
    pattern = pat;
    @(negedge board_clk);
    if (disturb) begin
      SW = pat;
      tick = 1'b1;
    end
    @(negedge board_clk);
    tick = 1'b0;
    if (disturb) begin
      check("capt_tick_game", {3'b0, game}, 4'd1);
      check("capt_tick_count", count, exp_count);
      start = 1'b1;
      @(negedge board_clk);
      start = 1'b0;
      check("play_start_target", target, pat);
      check("play_start_count", count, exp_count);
      check("play_start_patreq", {3'b0, pat_req}, 4'd0);
    end
    for (int i = 0; i < int'(n_wrong); i++) begin
      SW = wrong_sw;
      tick = 1'b1;
      @(negedge board_clk);
      tick = 1'b0;
      if ((i + 1 < int'(n_wrong)) || hit) begin
        SW = pat;
        @(negedge board_clk);
      end
    end
    if (hit) begin
      SW = pat;
      tick = 1'b1;
      @(negedge board_clk);
      tick = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge board_clk);
    start = 1'b0;
  endtask

  initial begin : stim
    logic [3:0] pats [10];
    pats = '{4'b0000, 4'b1111, 4'b1010, 4'b0110, 4'b1001,
             4'b0001, 4'b1000, 4'b0111, 4'b1100, 4'b0011};

    repeat (2) @(negedge board_clk);
    rst_btn = 1'b0;
    chk_en  = 1'b1;
    check("rst_count", count, 4'd0);
    check("rst_game", {3'b0, game}, 4'd0);
    check("rst_target", target, 4'd0);

    // Game 1: hit on first tick, then a full-window miss, then a disturbed hit
    pattern = 4'b1011;
    pulse_start();
    check("load_patreq", {3'b0, pat_req}, 4'd1);
    play_round(4'b1011, 4'b0000, 0, 1'b1, 1'b0, 4'd0);
    check("r1_done", {3'b0, round_done}, 4'd1);
    check("r1_res", {3'b0, roundres}, 4'd1);
    check("r1_score", score, 4'd1);
    check("r1_count", count, 4'd1);
    @(negedge board_clk);
    play_round(4'b0101, 4'b0000, WINDOW, 1'b0, 1'b0, 4'd1);
    check("r2_done", {3'b0, round_done}, 4'd1);
    check("r2_res", {3'b0, roundres}, 4'd0);
    check("r2_score", score, 4'd1);
    check("r2_count", count, 4'd2);
    @(negedge board_clk);
    play_round(4'b1110, 4'b0110, 2, 1'b1, 1'b1, 4'd2);
    check("r3_count", count, 4'd3);
    @(negedge board_clk);

    // Reset in the middle of round 4
    pattern = 4'b0011;
    @(negedge board_clk);
    @(negedge board_clk);
    SW = 4'b0000;
    tick = 1'b1;
    @(negedge board_clk);
    tick = 1'b0;
    rst_btn = 1'b1;
    @(negedge board_clk);
    rst_btn = 1'b0;
    check("midrst_game", {3'b0, game}, 4'd0);
    check("midrst_count", count, 4'd0);
    check("midrst_score", score, 4'd0);
    check("midrst_target", target, 4'd0);
    check("midrst_res", {3'b0, roundres}, 4'd0);
    @(negedge board_clk);

    // Game 2: every round hit, with varying numbers of early wrong ticks
    pulse_start();
    for (int r = 0; r < int'(ROUNDS); r++) begin
      play_round(pats[r], ~pats[r], r % 4, 1'b1, 1'b0, 4'(r));
      @(negedge board_clk);
    end
    check("over_count", count, 4'd10);
    check("over_score", score, 4'd10);
    check("over_game", {3'b0, game}, 4'd0);
    SW = pats[ROUNDS-1];
    tick = 1'b1;
    @(negedge board_clk);
    tick = 1'b0;
    check("over_tick_count", count, 4'd10);
    check("over_tick_game", {3'b0, game}, 4'd0);
    check("over_hold_target", target, 4'b0011);

    // Game 3: hit, then three consecutive misses
    pulse_start();
    check("restart_count", count, 4'd0);
    check("restart_game", {3'b0, game}, 4'd1);
    play_round(4'b0100, 4'b0000, 1, 1'b1, 1'b0, 4'd0);
    for (int r = 0; r < 3; r++) begin
      @(negedge board_clk);
      play_round(4'b1101, 4'b0010, WINDOW, 1'b0, 1'b0, 4'(r + 1));
    end
    @(negedge board_clk);
    check("ml_count", count, 4'd4);
    check("ml_score", score, 4'd1);
`ifdef MISS_LIMIT_EN
    check("ml_game", {3'b0, game}, 4'd0);
    check("ml_patreq", {3'b0, pat_req}, 4'd0);
`else
    check("ml_game", {3'b0, game}, 4'd1);
    check("ml_patreq", {3'b0, pat_req}, 4'd1);
`endif

    // Reset and start in the same cycle: reset wins
    rst_btn = 1'b1;
    start   = 1'b1;
    @(negedge board_clk);
    rst_btn = 1'b0;
    start   = 1'b0;
    check("rst_prio_game", {3'b0, game}, 4'd0);
    check("rst_prio_patreq", {3'b0, pat_req}, 4'd0);
    check("rst_prio_count", count, 4'd0);
    repeat (3) @(negedge board_clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
